// File: rtl/tpc_pkg.sv
// Shared types and helpers for the test-pattern counter.
package tpc_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Value a channel starts from (and wraps back to): 0 counting up, all-ones counting down.
  function automatic logic [63:0] start_value(dir_e dir, int unsigned width);
    logic [63:0] v;
    v = '0;
    if (dir == DIR_DOWN) begin
      v = (64'd1 << width) - 64'd1;
    end
    return v;
  endfunction

endpackage

// File: rtl/tpc_channel.sv
// One test-pattern channel: dir/step config, counter and wrap-to-start rule.
// Optional wrap flag output is built only with TPC_WRAP_FLAG_EN defined.
module tpc_channel
  import tpc_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  dir_e              load_dir,
  input  logic [STEP_W-1:0] load_step,
  input  logic              advance,
  output logic [WIDTH-1:0]  cnt
`ifdef TPC_WRAP_FLAG_EN
  ,
  output logic              wrap
`endif
);

  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

  dir_e              dir_q;
  logic [STEP_W-1:0] step_q;
  logic [WIDTH-1:0]  cnt_q;
  logic [WIDTH-1:0]  step_ext;
  logic [WIDTH-1:0]  start_cnt;
  logic [WIDTH-1:0]  cnt_nxt;
  logic              wrap_now;

  assign step_ext = WIDTH'(step_q);
  assign cnt      = cnt_q;

  // Next value: compare at WIDTH bits before stepping so no overflow is ever formed.
  always_comb begin
    wrap_now  = 1'b0;
    start_cnt = WIDTH'(start_value(dir_q, WIDTH));
    cnt_nxt   = cnt_q;
    if (dir_q == DIR_UP) begin
      wrap_now = (cnt_q > (MAX - step_ext));
      cnt_nxt  = wrap_now ? start_cnt : (cnt_q + step_ext);
    end else begin
      wrap_now = (cnt_q < step_ext);
      cnt_nxt  = wrap_now ? start_cnt : (cnt_q - step_ext);
    end
  end

  // Config and counter registers; a load restarts the channel from its start value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q  <= DIR_UP;
      step_q <= STEP_W'(1);
      cnt_q  <= '0;
    end else if (load) begin
      dir_q  <= load_dir;
      step_q <= (load_step == '0) ? STEP_W'(1) : load_step;
      cnt_q  <= WIDTH'(start_value(load_dir, WIDTH));
    end else if (advance) begin
      cnt_q  <= cnt_nxt;
    end
  end

`ifdef TPC_WRAP_FLAG_EN
  // Wrap flag travels with the beat it describes and holds under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap <= 1'b0;
    end else if (load) begin
      wrap <= 1'b0;
    end else if (advance) begin
      wrap <= wrap_now;
    end
  end
`endif

endmodule

// File: rtl/test_pattern_counter.sv
// Multi-channel test-pattern generator behind a valid/ready handshake.
// Optional per-channel wrap flags via TPC_WRAP_FLAG_EN.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | out_valid low, counters hold, config accepted
// ST_RUN  | out_valid high, channels advance on accept
module test_pattern_counter
  import tpc_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int STEP_W   = 4,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_load,
  input  logic [CH_W-1:0]           cfg_ch,
  input  logic                      cfg_dir,
  input  logic [STEP_W-1:0]         cfg_step,
  input  logic                      start,
  input  logic                      stop,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data
`ifdef TPC_WRAP_FLAG_EN
  ,
  output logic [CHANNELS-1:0]       out_wrap
`endif
);

  state_e state_q;
  state_e state_d;
  logic   accept;
  logic   cfg_ok;
  dir_e   cfg_dir_e;

  assign out_valid = (state_q == ST_RUN);
  assign accept    = out_valid & out_ready;
  assign cfg_ok    = cfg_load & (state_q == ST_IDLE);
  assign cfg_dir_e = cfg_dir ? DIR_DOWN : DIR_UP;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; stop has priority over start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start && !stop) state_d = ST_RUN;
      ST_RUN:  if (stop)           state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic load_i;
    assign load_i = cfg_ok && (cfg_ch == CH_W'(i));

    tpc_channel #(
      .WIDTH  (WIDTH),
      .STEP_W (STEP_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load_i),
      .load_dir  (cfg_dir_e),
      .load_step (cfg_step),
      .advance   (accept),
      .cnt       (out_data[i*WIDTH +: WIDTH])
`ifdef TPC_WRAP_FLAG_EN
      ,
      .wrap      (out_wrap[i])
`endif
    );
  end

endmodule

// File: tb/tb_test_pattern_counter.sv
// Self-checking bench for test_pattern_counter (WIDTH=8, CHANNELS=4).
module tb_test_pattern_counter;

  localparam int W   = 8;
  localparam int CH  = 4;
  localparam int SW  = 4;
  localparam int MAX = 255;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cfg_load;
  logic [1:0]      cfg_ch;
  logic            cfg_dir;
  logic [SW-1:0]   cfg_step;
  logic            start;
  logic            stop;
  logic            out_valid;
  logic            out_ready;
  logic [CH*W-1:0] out_data;
`ifdef TPC_WRAP_FLAG_EN
  logic [CH-1:0]   out_wrap;
`endif

  int checks = 0;
  int errors = 0;

  test_pattern_counter #(.WIDTH(W), .CHANNELS(CH), .STEP_W(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_load  (cfg_load),
    .cfg_ch    (cfg_ch),
    .cfg_dir   (cfg_dir),
    .cfg_step  (cfg_step),
    .start     (start),
    .stop      (stop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef TPC_WRAP_FLAG_EN
    ,
    .out_wrap  (out_wrap)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] chv(input int i);
    return out_data[i*W +: W];
  endfunction

  // Behavioural model: plain integer arithmetic on the stated counting rules.
  int m_cnt  [CH];
  int m_step [CH];
  bit m_down [CH];
  bit m_wrap [CH];
  bit m_valid;
  int m_n;

  function automatic logic [CH*W-1:0] exp_data();
    logic [CH*W-1:0] r;
    r = '0;
    for (int i = 0; i < CH; i++) r[i*W +: W] = m_cnt[i][W-1:0];
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_valid = 1'b0;
        for (int i = 0; i < CH; i++) begin
          m_cnt[i] = 0; m_step[i] = 1; m_down[i] = 1'b0; m_wrap[i] = 1'b0;
        end
      end else begin
        if (m_valid && out_ready) begin
          for (int i = 0; i < CH; i++) begin
            if (!m_down[i]) begin
              m_n = m_cnt[i] + m_step[i];
              m_wrap[i] = (m_n > MAX);
              if (m_n > MAX) m_n = 0;
            end else begin
              m_n = m_cnt[i] - m_step[i];
              m_wrap[i] = (m_n < 0);
              if (m_n < 0) m_n = MAX;
            end
            m_cnt[i] = m_n;
          end
        end
        if (!m_valid && cfg_load && int'(cfg_ch) < CH) begin
          m_down[int'(cfg_ch)] = cfg_dir;
          m_step[int'(cfg_ch)] = (cfg_step == 0) ? 1 : int'(cfg_step);
          m_cnt[int'(cfg_ch)]  = cfg_dir ? MAX : 0;
          m_wrap[int'(cfg_ch)] = 1'b0;
        end
        m_valid = stop ? 1'b0 : (start ? 1'b1 : m_valid);
      end
    end
  end

  // Cycle-by-cycle comparison against the model, well after the clock edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rst_n) begin
        check("model_valid", 64'(out_valid), 64'(m_valid));
        check("model_data", 64'(out_data), 64'(exp_data()));
`ifdef TPC_WRAP_FLAG_EN
        for (int i = 0; i < CH; i++) check("model_wrap", 64'(out_wrap[i]), 64'(m_wrap[i]));
`endif
      end
    end
  end

  task automatic cfg(input int ch, input bit dir, input int step);
    cfg_load = 1'b1;
    cfg_ch   = 2'(ch);
    cfg_dir  = dir;
    cfg_step = SW'(step);
  endtask

  // Directed stimulus with hand-computed expectations; inputs change on falling edges.
  initial begin
    rst_n = 1'b0; cfg_load = 1'b0; cfg_ch = '0; cfg_dir = 1'b0; cfg_step = '0;
    start = 1'b0; stop = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    rst_n = 1'b1;

    @(negedge clk); cfg(0, 1'b0, 3);
    @(negedge clk); cfg(1, 1'b1, 4);
    @(negedge clk); cfg_load = 1'b0;
    check("load_down_start", 64'(chv(1)), 64'd255);
    check("idle_valid", 64'(out_valid), 64'd0);

    start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k <= 90; k++) begin
      if (k == 0)  begin check("first_ch0", 64'(chv(0)), 64'd0);   check("first_ch1", 64'(chv(1)), 64'd255); end
      if (k == 1)  begin check("second_ch0", 64'(chv(0)), 64'd3);  check("second_ch1", 64'(chv(1)), 64'd251); end
      if (k == 63) check("ch1_last", 64'(chv(1)), 64'd3);
      if (k == 64) begin
        check("ch1_wrap", 64'(chv(1)), 64'd255);
`ifdef TPC_WRAP_FLAG_EN
        check("ch1_wrap_flag", 64'(out_wrap[1]), 64'd1);
`endif
      end
      if (k == 85) check("ch0_max", 64'(chv(0)), 64'd255);
      if (k == 86) begin
        check("ch0_wrap", 64'(chv(0)), 64'd0);
`ifdef TPC_WRAP_FLAG_EN
        check("ch0_wrap_flag", 64'(out_wrap[0]), 64'd1);
`endif
      end
      if (k == 90) check("ch2_step1", 64'(chv(2)), 64'd90);
      @(negedge clk);
    end

    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    check("stop_valid", 64'(out_valid), 64'd0);

    cfg(0, 1'b0, 3);
    @(negedge clk); cfg_load = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("bp_b0", 64'(chv(0)), 64'd0);
    @(negedge clk); check("bp_b1", 64'(chv(0)), 64'd3);
    @(negedge clk); check("bp_b2", 64'(chv(0)), 64'd6);
    out_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("bp_hold_data", 64'(chv(0)), 64'd6);
      check("bp_hold_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(negedge clk); check("bp_release", 64'(chv(0)), 64'd9);

    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    check("stop_acc_valid", 64'(out_valid), 64'd0);
    check("stop_acc_data", 64'(chv(0)), 64'd12);
    @(negedge clk);
    check("stop_hold", 64'(chv(0)), 64'd12);

    start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    check("start_stop_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("start_stop_valid2", 64'(out_valid), 64'd0);

    start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("run_resume", 64'(chv(0)), 64'd12);
    cfg(0, 1'b0, 0);
    @(negedge clk); cfg_load = 1'b0;
    check("run_cfg_ignored", 64'(chv(0)), 64'd15);
    @(negedge clk); check("run_step_kept", 64'(chv(0)), 64'd18);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    check("stop2_data", 64'(chv(0)), 64'd21);

    cfg(0, 1'b0, 0);
    @(negedge clk); cfg_load = 1'b0;
    check("step0_load", 64'(chv(0)), 64'd0);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("step0_b0", 64'(chv(0)), 64'd0);
    @(negedge clk); check("step0_b1", 64'(chv(0)), 64'd1);
    @(negedge clk); check("step0_b2", 64'(chv(0)), 64'd2);

    repeat (126) @(negedge clk);
    check("pre_rst_128", 64'(chv(0)), 64'd128);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_data", 64'(out_data), 64'd0);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("post_rst_ch0_b0", 64'(chv(0)), 64'd0);
    check("post_rst_ch1_b0", 64'(chv(1)), 64'd0);
    @(negedge clk);
    check("post_rst_ch0_b1", 64'(chv(0)), 64'd1);
    check("post_rst_ch1_b1", 64'(chv(1)), 64'd1);
    check("post_rst_ch3_b1", 64'(chv(3)), 64'd1);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
